// File: rtl/seq_mult_if.sv
// Operand/product handshake bundle for seq_mult.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     inp1;
    logic [WIDTH-1:0]     inp2;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, in_signed, inp1, inp2, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, in_signed, inp1, inp2, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or signed per operation.
// Signed operands are multiplied as magnitudes and the sign is applied when the product is loaded.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_mult_if.slave  bus,
    output logic [1:0] o_dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 w_last;
    logic                 w_neg;

    always_comb begin
        w_next = r_state;
        w_last = (r_cnt == LAST_BIT);
        w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
        // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude
        w_abs1 = (bus.in_signed && bus.inp1[WIDTH-1]) ? -bus.inp1 : bus.inp1;
        w_abs2 = (bus.in_signed && bus.inp2[WIDTH-1]) ? -bus.inp2 : bus.inp2;
        w_neg  = bus.in_signed & (bus.inp1[WIDTH-1] ^ bus.inp2[WIDTH-1]);
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_BUSY;
            S_BUSY:  if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
            r_busy      <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs1};
                        r_mplier <= w_abs2;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= r_neg ? -w_sum : w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
    assign bus.busy      = r_busy;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: a WIDTH=4 and a WIDTH=8 instance, directed cases plus randomized traffic.
// Expected products come from integer arithmetic and are checked by per-instance output monitors.
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] dbg4;
    logic [1:0] dbg8;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int ready4_mode = 0;
    int ready8_mode = 0;
    int last_acc4 = -100;
    int last_acc8 = -100;
    logic prev_ov4 = 1'b0;
    logic prev_ov8 = 1'b0;
    logic [7:0]  exp4_q[$];
    logic [15:0] exp8_q[$];
    int acc4_q[$];
    int acc8_q[$];

    seq_mult_if #(.WIDTH(4)) bus4();
    seq_mult_if #(.WIDTH(8)) bus8();

    seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .o_dbg_state(dbg4));
    seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .o_dbg_state(dbg8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 8'(ia * ib);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drv4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
        bus4.inp1 = a;
        bus4.inp2 = b;
        bus4.in_signed = s;
        bus4.in_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (bus4.in_ready) break;
            if (i > 100) begin
                timeout_fail("accept4");
                bus4.in_valid = 1'b0;
                return;
            end
        end
        if (last_acc4 >= 0) check("issue_interval4_ge6", 32'(cyc + 1 - last_acc4 >= 6), 1);
        last_acc4 = cyc + 1;
        exp4_q.push_back(exp);
        acc4_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
        bus8.inp1 = a;
        bus8.inp2 = b;
        bus8.in_signed = s;
        bus8.in_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (bus8.in_ready) break;
            if (i > 100) begin
                timeout_fail("accept8");
                bus8.in_valid = 1'b0;
                return;
            end
        end
        if (last_acc8 >= 0) check("issue_interval8_ge10", 32'(cyc + 1 - last_acc8 >= 10), 1);
        last_acc8 = cyc + 1;
        exp8_q.push_back(exp);
        acc8_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input bit w8);
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (w8 ? (exp8_q.size() == 0 && bus8.in_ready) : (exp4_q.size() == 0 && bus4.in_ready)) break;
            if (i > 300) begin
                timeout_fail(w8 ? "drain8" : "drain4");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitors choose out_ready first, then judge the handshake the next rising edge will see.
    always @(negedge clk) begin
        bus4.out_ready = (ready4_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready4_mode == 1);
        if (bus4.out_valid && !prev_ov4 && acc4_q.size() > 0)
            check("latency4", 32'(cyc - acc4_q[0]), 4);
        if (bus4.out_valid && bus4.out_ready) begin
            if (exp4_q.size() == 0) begin
                timeout_fail("unexpected_output4");
            end else begin
                check("product4", 32'(bus4.product), 32'(exp4_q.pop_front()));
                check("in_ready4_low_in_done", 32'(bus4.in_ready), 0);
                void'(acc4_q.pop_front());
            end
        end
        prev_ov4 = bus4.out_valid;
    end

    always @(negedge clk) begin
        bus8.out_ready = (ready8_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready8_mode == 1);
        if (bus8.out_valid && !prev_ov8 && acc8_q.size() > 0)
            check("latency8", 32'(cyc - acc8_q[0]), 8);
        if (bus8.out_valid && bus8.out_ready) begin
            if (exp8_q.size() == 0) begin
                timeout_fail("unexpected_output8");
            end else begin
                check("product8", 32'(bus8.product), 32'(exp8_q.pop_front()));
                check("in_ready8_low_in_done", 32'(bus8.in_ready), 0);
                void'(acc8_q.pop_front());
            end
        end
        prev_ov8 = bus8.out_valid;
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_signed = 1'b0; bus4.inp1 = '0; bus4.inp2 = '0;
        bus8.in_valid = 1'b0; bus8.in_signed = 1'b0; bus8.inp1 = '0; bus8.inp2 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready4", 32'(bus4.in_ready), 1);
        check("rst_out_valid4", 32'(bus4.out_valid), 0);
        check("rst_busy4", 32'(bus4.busy), 0);
        check("rst_product4", 32'(bus4.product), 0);
        check("rst_in_ready8", 32'(bus8.in_ready), 1);
        check("rst_out_valid8", 32'(bus8.out_valid), 0);
        check("rst_busy8", 32'(bus8.busy), 0);
        check("rst_product8", 32'(bus8.product), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 15*15 unsigned on the 4-bit instance, ready held high in advance
        ready4_mode = 1;
        drv4(4'hF, 4'hF, 1'b0, 8'hE1);
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_in_ready4", 32'(bus4.in_ready), 0);
            check("busy_flag4", 32'(bus4.busy), 1);
        end
        wait_drain(1'b0);

        // Signed corner cases back to back, then unsigned with in_signed toggling mid-operation
        ready8_mode = 1;
        drv8(8'h80, 8'h80, 1'b1, 16'h4000);
        drv8(8'h80, 8'h7F, 1'b1, 16'hC080);
        drv8(8'hFF, 8'h01, 1'b1, 16'hFFFF);
        drv8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        bus8.in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 bus8.in_signed = ~bus8.in_signed;
        end
        wait_drain(1'b1);

        // Backpressure: hold DONE for 10 cycles while in_valid pulses
        ready8_mode = 0;
        drv8(8'h12, 8'h34, 1'b0, 16'h03A8);
        bus8.in_valid = 1'b0;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (bus8.out_valid) break;
            if (i > 20) begin
                timeout_fail("bp_out_valid");
                break;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus8.in_valid = i[0];
            bus8.inp1 = 8'h55;
            @(negedge clk);
            check("bp_out_valid", 32'(bus8.out_valid), 1);
            check("bp_product", 32'(bus8.product), 32'h03A8);
            check("bp_busy", 32'(bus8.busy), 1);
            check("bp_in_ready", 32'(bus8.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        ready8_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("after_hs_in_ready", 32'(bus8.in_ready), 1);
        check("after_hs_out_valid", 32'(bus8.out_valid), 0);
        check("after_hs_busy", 32'(bus8.busy), 0);
        @(posedge clk);
        #1;
        drv8(8'd7, 8'd9, 1'b0, 16'h003F);
        bus8.in_valid = 1'b0;
        wait_drain(1'b1);

        // Reset two cycles into an operation discards it
        drv8(8'h0A, 8'h0B, 1'b0, 16'h006E);
        bus8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus8.in_ready), 1);
        check("midrst_out_valid", 32'(bus8.out_valid), 0);
        check("midrst_busy", 32'(bus8.busy), 0);
        check("midrst_product", 32'(bus8.product), 0);
        exp8_q.delete();
        acc8_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        check("no_out_valid_after_reset", 32'(seen), 0);
        @(posedge clk);
        #1;
        drv8(8'd3, 8'd5, 1'b0, 16'h000F);
        bus8.in_valid = 1'b0;
        wait_drain(1'b1);

        // Exhaustive 4-bit, both modes, back-to-back with random out_ready
        ready4_mode = 2;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 2; s++)
                    drv4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s)));
        bus4.in_valid = 1'b0;
        wait_drain(1'b0);
        ready4_mode = 1;

        // Random 8-bit traffic with idle gaps and random out_ready
        ready8_mode = 2;
        repeat (150) begin
            logic [7:0] a;
            logic [7:0] b;
            logic s;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            drv8(a, b, s, ref8(a, b, s));
            if ($urandom_range(0, 3) == 0) begin
                bus8.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bus8.in_valid = 1'b0;
        wait_drain(1'b1);
        ready8_mode = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
